// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encodings
// and default parameter values.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: dout is the head entry combinationally, a push is visible the next cycle.
// Pop while empty is ignored; push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit tells full from empty when the indices coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 3-sample voting, parity/stop checks and a receive FIFO.
// rdy rises one cycle after the last-stop decision tick; frames arriving while the FIFO is full are dropped (sticky overrun).
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 tick,
  input  logic                 rd_en,
  input  logic                 clear_err,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] out_rx,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS+1);
  localparam int W  = DATA_BITS + 2;
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 armed_q, armed_d, ovr_q, ovr_d;
  logic [W-1:0]         hold_q, hold_d;
  logic                 vote, at_dec, at_end, push;
  logic [W-1:0]         push_dat, fifo_dout, head;
  logic                 fifo_empty, fifo_full;

  uart_rx_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .din   (push_dat),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    armed_d   = armed_q;
    push      = 1'b0;
    push_dat  = {ferr_q | ~vote, perr_q, data_q};
    vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    at_dec    = tick && (cnt_q == CNT_DEC);
    at_end    = tick && (cnt_q == CNT_LAST);

    if (tick && state_q != RX_IDLE) begin
      cnt_d = at_end ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) s0_d = rx_s_q;
      if (cnt_q == CNT_S1) s1_d = rx_s_q;
    end

    case (state_q)
      RX_IDLE: begin
        if (tick) begin
          if (!armed_q) begin
            if (rx_s_q) armed_d = 1'b1;
          end else if (!rx_s_q) begin
            state_d = RX_START;
            cnt_d   = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
      end
      RX_START: begin
        if (at_dec && vote) begin
          state_d = RX_IDLE;
        end else if (at_end) begin
          state_d = RX_DATA;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (at_dec) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_q == BW'(i)) data_d[i] = vote;
          end
        end
        if (at_end) begin
          if (bit_q == BW'(DATA_BITS-1)) begin
            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (at_dec && (vote != ((^data_q) ^ PAR_ODD))) perr_d = 1'b1;
        if (at_end) begin
          state_d = RX_STOP;
          bit_d   = '0;
        end
      end
      RX_STOP: begin
        if (at_dec) begin
          if (!vote) ferr_d = 1'b1;
          // Leave half a bit early so the next start edge is never missed.
          if (bit_q == BW'(STOP_BITS-1)) begin
            push    = 1'b1;
            state_d = RX_IDLE;
            if (!vote || ferr_q) armed_d = 1'b0;
          end
        end else if (at_end) begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (clear_err) ovr_d = 1'b0;
    if (push && fifo_full && !rd_en) ovr_d = 1'b1;
    head   = fifo_empty ? hold_q : fifo_dout;
    hold_d = head;
  end

  assign rdy        = !fifo_empty;
  assign out_rx     = head[DATA_BITS-1:0];
  assign parity_err = head[DATA_BITS];
  assign frame_err  = head[DATA_BITS+1];
  assign overrun    = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      armed_q   <= 1'b1;
      ovr_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      armed_q   <= armed_d;
      ovr_q     <= ovr_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: an 8N1 receiver (A) and an 8E1 receiver (B) share clock, tick and reset.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_a, rx_b, tick, rd_a, rd_b, clear_err;
  logic       rdy_a, fe_a, pe_a, ov_a, rdy_b, fe_b, pe_b, ov_b;
  logic [7:0] out_a, out_b;
  logic       step_rd;
  int         n_vec = 0;
  int         n_bad = 0;

  uart_rx_param dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .tick(tick), .rd_en(rd_a), .clear_err(clear_err),
    .rdy(rdy_a), .out_rx(out_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .tick(tick), .rd_en(rd_b), .clear_err(clear_err),
    .rdy(rdy_b), .out_rx(out_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         par_en;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One oversample tick period: rx set at a negedge, tick pulses on the 4th cycle.
  task automatic step(input bit sel, input logic lvl);
    if (sel) rx_b = lvl; else rx_a = lvl;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    rd_a = step_rd;
    @(negedge clk);
    tick = 1'b0;
    rd_a = 1'b0;
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) step(sel, 1'b1);
  endtask

  function automatic logic [11:0] mkframe(input logic [7:0] d, input bit has_par,
                                          input logic par, input logic stop);
    logic [11:0] f;
    f      = 12'hFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (has_par) begin
      f[9]  = par;
      f[10] = stop;
    end else begin
      f[9] = stop;
    end
    return f;
  endfunction

  // Steps g_from..g_to (1-based, 16 per bit); step 'glitch' is inverted.
  task automatic frame_steps(input bit sel, input logic [11:0] f, input int g_from,
                             input int g_to, input int glitch);
    for (int g = g_from; g <= g_to; g++) begin
      logic l;
      l = f[(g-1)/16];
      if (g == glitch) l = ~l;
      step(sel, l);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic par,
                      input logic stop);
    frame_steps(sel, mkframe(d, has_par, par, stop), 1, (has_par ? 11 : 10) * 16, 0);
    idle(sel, 4);
  endtask

  task automatic pop(input bit sel);
    if (sel) rd_b = 1'b1; else rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    rd_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_head(input bit sel, input string name, input logic [7:0] d,
                            input logic fe, input logic pe);
    chk({name, ".rdy"},   32'(sel ? rdy_b : rdy_a), 32'd1);
    chk({name, ".data"},  32'(sel ? out_b : out_a), 32'(d));
    chk({name, ".ferr"},  32'(sel ? fe_b : fe_a),   32'(fe));
    chk({name, ".perr"},  32'(sel ? pe_b : pe_a),   32'(pe));
  endtask

  initial begin
    logic [11:0] f;
    vecs[0] = '{0, 8'hA5, 0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h3C, 0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h01, 1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{1, 8'h01, 1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{0, 8'h55, 0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[5] = '{1, 8'hFF, 1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h03, 1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h80, 1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; tick = 1'b0;
    rd_a = 1'b0; rd_b = 1'b0; clear_err = 1'b0; step_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rdy",  32'(rdy_a), 32'd0);
    chk("rst.out",  32'(out_a), 32'd0);
    chk("rst.ferr", 32'(fe_a),  32'd0);
    chk("rst.perr", 32'(pe_a),  32'd0);
    chk("rst.ovr",  32'(ov_a),  32'd0);
    rst_n = 1'b1;
    idle(0, 4);

    // 8N1 baseline with exact rdy timing around the stop decision tick.
    f = mkframe(8'hA5, 0, 1'b0, 1'b1);
    frame_steps(0, f, 1, 154, 0);
    chk("base.rdy_pre", 32'(rdy_a), 32'd0);
    frame_steps(0, f, 155, 155, 0);
    check_head(0, "base", 8'hA5, 1'b0, 1'b0);
    frame_steps(0, f, 156, 160, 0);
    idle(0, 2);
    pop(0);
    chk("base.rdy_post", 32'(rdy_a), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sel, vecs[i].d, vecs[i].par_en, vecs[i].par, vecs[i].stop);
      idle(vecs[i].sel, 2);
      check_head(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_fe, vecs[i].exp_pe);
      pop(vecs[i].sel);
      chk($sformatf("vec%0d.empty", i), 32'(vecs[i].sel ? rdy_b : rdy_a), 32'd0);
    end

    // False start: 3 low ticks only.
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    idle(0, 40);
    chk("fstart.rdy", 32'(rdy_a), 32'd0);
    send(0, 8'h3C, 0, 1'b0, 1'b1);
    check_head(0, "fstart_next", 8'h3C, 1'b0, 1'b0);
    pop(0);

    // Single-tick glitch at the middle sample of data bit 2.
    frame_steps(0, mkframe(8'h00, 0, 1'b0, 1'b1), 1, 160, 58);
    idle(0, 4);
    check_head(0, "glitch", 8'h00, 1'b0, 1'b0);
    pop(0);

    // Break: line low for three frame times, then released.
    for (int i = 0; i < 480; i++) step(0, 1'b0);
    idle(0, 20);
    check_head(0, "break", 8'h00, 1'b1, 1'b0);
    pop(0);
    chk("break.single", 32'(rdy_a), 32'd0);
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    check_head(0, "break_resume", 8'h5A, 1'b0, 1'b0);
    pop(0);

    // Overrun: fifth frame into a full FIFO is dropped.
    for (int i = 0; i < 4; i++) send(0, 8'h11 + 8'(i), 0, 1'b0, 1'b1);
    chk("ovr.full_no_ovr", 32'(ov_a), 32'd0);
    send(0, 8'h15, 0, 1'b0, 1'b1);
    chk("ovr.set", 32'(ov_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr.rd%0d", i), 32'(out_a), 32'h11 + 32'(i));
      pop(0);
    end
    chk("ovr.drained", 32'(rdy_a), 32'd0);
    chk("ovr.sticky", 32'(ov_a), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("ovr.cleared", 32'(ov_a), 32'd0);

    // Push into a full FIFO with a read in the same cycle is accepted.
    for (int i = 0; i < 4; i++) send(0, 8'h21 + 8'(i), 0, 1'b0, 1'b1);
    f = mkframe(8'h25, 0, 1'b0, 1'b1);
    frame_steps(0, f, 1, 154, 0);
    step_rd = 1'b1;
    frame_steps(0, f, 155, 155, 0);
    step_rd = 1'b0;
    frame_steps(0, f, 156, 160, 0);
    idle(0, 4);
    chk("rdpush.no_ovr", 32'(ov_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rdpush.rd%0d", i), 32'(out_a), 32'h22 + 32'(i));
      pop(0);
    end
    chk("rdpush.drained", 32'(rdy_a), 32'd0);

    // Reset in the middle of a frame with a pending entry and overrun set.
    send(0, 8'h42, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 8'h43, 0, 1'b0, 1'b1);
    frame_steps(0, mkframe(8'h7E, 0, 1'b0, 1'b1), 1, 60, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.rdy",  32'(rdy_a), 32'd0);
    chk("mrst.out",  32'(out_a), 32'd0);
    chk("mrst.ferr", 32'(fe_a),  32'd0);
    chk("mrst.perr", 32'(pe_a),  32'd0);
    chk("mrst.ovr",  32'(ov_a),  32'd0);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 4);
    send(0, 8'h7E, 0, 1'b0, 1'b1);
    check_head(0, "mrst_next", 8'h7E, 1'b0, 1'b0);
    pop(0);
    chk("mrst.empty", 32'(rdy_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
